// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result handshake bundle for pipelined_add_sub
interface pipelined_add_sub_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined ripple-carry adder/subtractor, one chunk per stage
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst,
    pipelined_add_sub_if.slave io
);
    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0]  opa_q   [STAGES];
    logic [WIDTH-1:0]  opa_d   [STAGES];
    logic [WIDTH-1:0]  opb_q   [STAGES];
    logic [WIDTH-1:0]  opb_d   [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              advance;

    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_s   [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [CW:0]       chunk   [STAGES];

    // Operand B is inverted at entry, so the mode travels as the stored effective B
    // and the stage-0 carry; later stages never need the sub bit itself.
    always_comb begin
        advance  = !valid_q[STAGES-1] || io.out_ready;
        src_a[0] = io.a;
        src_b[0] = io.sub ? ~io.b : io.b;
        src_s[0] = '0;
        src_c[0] = io.sub ? 1'b1 : io.c_in;
        src_v[0] = io.in_valid && advance;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = opa_q[k-1];
            src_b[k] = opb_q[k-1];
            src_s[k] = sum_q[k-1];
            src_c[k] = carry_q[k-1];
            src_v[k] = valid_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, src_a[k][k*CW +: CW]}
                     + {1'b0, src_b[k][k*CW +: CW]}
                     + {{CW{1'b0}}, src_c[k]};
            opa_d[k]            = src_a[k];
            opb_d[k]            = src_b[k];
            sum_d[k]            = src_s[k];
            sum_d[k][k*CW +: CW] = chunk[k][CW-1:0];
            carry_d[k]          = chunk[k][CW];
            valid_d[k]          = src_v[k];
        end
        // a^b^s at the MSB recovers the carry into the MSB.
        ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
              ^ sum_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign io.in_ready  = advance;
    assign io.out_valid = valid_q[STAGES-1];
    assign io.sum       = sum_q[STAGES-1];
    assign io.c_out     = carry_q[STAGES-1];
    assign io.overflow  = ovf_q;
    assign io.zero      = (sum_q[STAGES-1] == '0);
endmodule
